// File: rtl/video_pkg.sv
// Shared definitions for the HDMI decimate-and-pack path: pixel width,
// default frame geometry and the line FSM encoding.
package video_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned H_ACT_DEF    = 1920;
  localparam int unsigned V_ACT_DEF    = 1080;
  localparam int unsigned PACK_PIX_DEF = 8;
  localparam int unsigned CNT_W        = 11;

  typedef enum logic [1:0] {
    WAIT_VS   = 2'd0,
    WAIT_LINE = 2'd1,
    IN_LINE   = 2'd2,
    FLUSH     = 2'd3
  } fsm_t;

  // Output word width for a given number of packed pixels.
  function automatic int unsigned data_w(input int unsigned pack_pix);
    return PIX_W * pack_pix;
  endfunction

endpackage

// File: rtl/pix_packer.sv
// Places kept pixels LSB-first into a wide word and pushes full or
// zero-padded partial words; a push seen with i_full high is lost.
module pix_packer
  import video_pkg::*;
#(
  parameter int unsigned PACK_PIX = PACK_PIX_DEF,
  parameter int unsigned DATA_W   = PIX_W * PACK_PIX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pix_vld,
  input  logic [PIX_W-1:0]  i_pix,
  input  logic              i_flush,
  input  logic              i_clear,
  input  logic              i_full,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_pending_c,
  output logic              o_push_c
);

  localparam int unsigned SLOT_W = $clog2(PACK_PIX);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK_PIX - 1);

  logic [SLOT_W-1:0] r_slot;
  logic [DATA_W-1:0] r_acc;
  logic [SLOT_W-1:0] w_base_slot;
  logic [DATA_W-1:0] w_base_acc;
  logic [DATA_W-1:0] w_placed;
  logic              w_word_full;
  logic              w_flush;

  // A line-start clear and the first pixel of the line land in the same cycle.
  always_comb begin
    w_base_slot = i_clear ? '0 : r_slot;
    w_base_acc  = i_clear ? '0 : r_acc;
    w_placed    = w_base_acc | (DATA_W'(i_pix) << (PIX_W * w_base_slot));
    w_word_full = i_pix_vld & (w_base_slot == LAST_SLOT);
    w_flush     = i_flush & (r_slot != '0);
  end

  assign o_push_c    = w_word_full | w_flush;
  assign o_pending_c = (r_slot != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot    <= '0;
      r_acc     <= '0;
      o_wr_en   <= 1'b0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= o_push_c & ~i_full;
      if (o_push_c & ~i_full) begin
        o_wr_data <= w_word_full ? w_placed : r_acc;
      end
      if (w_word_full | w_flush) begin
        r_slot <= '0;
        r_acc  <= '0;
      end else if (i_pix_vld) begin
        r_slot <= w_base_slot + SLOT_W'(1);
        r_acc  <= w_placed;
      end else if (i_clear) begin
        r_slot <= '0;
        r_acc  <= '0;
      end
    end
  end

endmodule

// File: rtl/video_decim_pack.sv
// 2:1 x 2:1 decimation of the HDMI pixel stream, packed into wide FIFO words,
// with frame/line markers and sticky overflow / format error flags.
module video_decim_pack
  import video_pkg::*;
#(
  parameter int unsigned H_ACT    = H_ACT_DEF,
  parameter int unsigned V_ACT    = V_ACT_DEF,
  parameter int unsigned PACK_PIX = PACK_PIX_DEF,
  parameter int unsigned DATA_W   = data_w(PACK_PIX)
) (
  input  logic              hdmi_pix_clk_in,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [PIX_W-1:0]  rgb565_in,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_start,
  output logic              line_done,
  output logic              ovf,
  output logic              frame_err
);

  fsm_t             r_state;
  fsm_t             w_state_nxt;
  logic             r_vs_q;
  logic             r_de_q;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic             r_seen_vs;
  logic             r_flush_q;
  logic             r_frame_start;
  logic             r_line_done;
  logic             r_ovf;
  logic             r_frame_err;

  logic             w_vs_rise;
  logic             w_de_rise;
  logic             w_de_fall;
  logic             w_line_pix;
  logic [CNT_W-1:0] w_pix_idx;
  logic             w_keep;
  logic             w_last_pix;
  logic             w_line_end;
  logic             w_pending;
  logic             w_push;

  // Edge detect, pixel index and keep rule; a vs edge discards the pixel it lands on.
  always_comb begin
    w_vs_rise  = vs_in & ~r_vs_q;
    w_de_rise  = de_in & ~r_de_q;
    w_de_fall  = ~de_in & r_de_q;
    w_line_pix = de_in & ~w_vs_rise &
                 (((r_state == WAIT_LINE) & w_de_rise) | (r_state == IN_LINE));
    w_pix_idx  = w_de_rise ? '0 : r_pix_cnt;
    w_keep     = w_line_pix & ~r_line_cnt[0] & ~w_pix_idx[0];
    w_last_pix = w_line_pix & ~r_line_cnt[0] & ~w_keep & ~w_pending &
                 (w_pix_idx == CNT_W'(H_ACT - 1));
    w_line_end = (r_state == IN_LINE) & w_de_fall;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_vs_rise) begin
      w_state_nxt = WAIT_LINE;
    end else begin
      case (r_state)
        WAIT_VS:   w_state_nxt = WAIT_VS;
        WAIT_LINE: if (w_de_rise) w_state_nxt = IN_LINE;
        IN_LINE:   if (w_de_fall) w_state_nxt = (~r_line_cnt[0] & w_pending) ? FLUSH : WAIT_LINE;
        FLUSH:     w_state_nxt = WAIT_LINE;
        default:   w_state_nxt = WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge hdmi_pix_clk_in or negedge rst) begin
    if (!rst) begin
      r_state       <= WAIT_VS;
      r_vs_q        <= 1'b0;
      r_de_q        <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_seen_vs     <= 1'b0;
      r_flush_q     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_ovf         <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vs_q  <= vs_in;
      r_de_q  <= de_in;
      if (w_de_rise) begin
        r_pix_cnt <= CNT_W'(1);
      end else if (de_in) begin
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      end
      if (w_vs_rise) begin
        r_line_cnt <= '0;
      end else if (w_line_end) begin
        r_line_cnt <= r_line_cnt + CNT_W'(1);
      end
      r_seen_vs     <= r_seen_vs | w_vs_rise;
      r_flush_q     <= (r_state == FLUSH);
      r_frame_start <= w_vs_rise;
      // Unpadded lines end on a full word; padded lines end one cycle after the flush push.
      r_line_done   <= w_last_pix | r_flush_q;
      r_ovf         <= r_ovf | (w_push & fifo_full);
      r_frame_err   <= r_frame_err |
                       (w_line_end & (r_pix_cnt != CNT_W'(H_ACT))) |
                       (w_vs_rise & r_seen_vs & (r_line_cnt != CNT_W'(V_ACT))) |
                       (w_vs_rise & de_in);
    end
  end

  assign frame_start = r_frame_start;
  assign line_done   = r_line_done;
  assign ovf         = r_ovf;
  assign frame_err   = r_frame_err;

  pix_packer #(
    .PACK_PIX (PACK_PIX),
    .DATA_W   (DATA_W)
  ) u_pix_packer (
    .clk         (hdmi_pix_clk_in),
    .rst_n       (rst),
    .i_pix_vld   (w_keep),
    .i_pix       (rgb565_in),
    .i_flush     (r_state == FLUSH),
    .i_clear     (w_de_rise | w_vs_rise),
    .i_full      (fifo_full),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .o_pending_c (w_pending),
    .o_push_c    (w_push)
  );

endmodule

// File: tb/tb_video_decim_pack.sv
// Randomized bench for video_decim_pack on a reduced 36x6 frame geometry,
// checked against a pixel-level decimate/pack reference model.
module tb_video_decim_pack;
  import video_pkg::*;

  localparam int unsigned H  = 36;
  localparam int unsigned V  = 6;
  localparam int unsigned PP = 8;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          vs_in;
  logic          de_in;
  logic [15:0]   rgb;
  logic          fifo_full;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          frame_start;
  logic          line_done;
  logic          ovf;
  logic          frame_err;

  always #5 clk = ~clk;

  video_decim_pack #(
    .H_ACT(H), .V_ACT(V), .PACK_PIX(PP), .DATA_W(DW)
  ) dut (
    .hdmi_pix_clk_in (clk),
    .rst             (rst),
    .vs_in           (vs_in),
    .de_in           (de_in),
    .rgb565_in       (rgb),
    .fifo_full       (fifo_full),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .frame_start     (frame_start),
    .line_done       (line_done),
    .ovf             (ovf),
    .frame_err       (frame_err)
  );

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs[$];
  int            n_wr, n_ld, n_fs;
  int            exp_wr, exp_ld, exp_fs;
  bit            prev_wr, ld_chk, ramp, drop_en;
  int            m_line, m_word;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en) begin
      n_wr++;
      obs.push_back(wr_data);
      if (exp_q.size() == 0) check("wr_unexpected", DW'(wr_en), DW'(0));
      else check("wr_data", wr_data, exp_q.pop_front());
    end
    if (line_done) begin
      n_ld++;
      if (ld_chk) check("line_done_after_wr", DW'(prev_wr), DW'(1));
    end
    if (frame_start) n_fs++;
    prev_wr = wr_en;
  endtask

  function automatic bit is_drop(input int w);
    return drop_en && (w >= 3) && (w < 6);
  endfunction

  // Drives one line; abort_at >= 0 raises vs on that pixel while de is high.
  task automatic drive_line(input int len, input int abort_at);
    logic [DW-1:0] acc;
    int            slot;
    bit            kept, hold, drop, full_word;
    logic [15:0]   p;
    kept = (m_line % 2) == 0;
    acc  = '0;
    slot = 0;
    hold = 0;
    for (int i = 0; i < len; i++) begin
      p = ramp ? 16'(i) : 16'($urandom);
      de_in = 1'b1;
      rgb = p;
      fifo_full = hold;
      hold = 0;
      full_word = 0;
      drop = 0;
      if (i == abort_at) begin
        vs_in = 1'b1;
        kept = 0;
        slot = 0;
        acc = '0;
        m_line = 0;
        m_word = 0;
        exp_fs++;
      end else if (i == abort_at + 2) begin
        vs_in = 1'b0;
      end
      if (kept && (i % 2 == 0) && i != abort_at) begin
        acc[slot*16 +: 16] = p;
        slot++;
        if (slot == PP) begin
          full_word = 1;
          drop = is_drop(m_word);
          if (drop) begin
            fifo_full = 1'b1;
            hold = 1;
          end else begin
            exp_q.push_back(acc);
            exp_wr++;
          end
          m_word++;
          acc = '0;
          slot = 0;
        end
      end
      tick();
      if (full_word && !drop) check("wr_latency", DW'(wr_en), DW'(1));
    end
    de_in = 1'b0;
    vs_in = 1'b0;
    fifo_full = hold;
    tick();
    if (kept && slot > 0) begin
      drop = is_drop(m_word);
      if (!drop) begin
        exp_q.push_back(acc);
        exp_wr++;
      end
      m_word++;
      exp_ld++;
      fifo_full = drop;
      tick();
      if (!drop) check("flush_wr", DW'(wr_en), DW'(1));
      tick();
    end
    fifo_full = 1'b0;
    repeat (5) tick();
    if (abort_at < 0) m_line++;
  endtask

  task automatic drive_frame(input int n_lines, input int bad_line, input int bad_len);
    vs_in = 1'b1;
    tick();
    tick();
    vs_in = 1'b0;
    exp_fs++;
    m_line = 0;
    m_word = 0;
    repeat (4) tick();
    for (int l = 0; l < n_lines; l++) drive_line((l == bad_line) ? bad_len : H, -1);
  endtask

  task automatic do_reset();
    de_in = 1'b0;
    vs_in = 1'b0;
    fifo_full = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  logic [DW-1:0] w0_exp, fl_exp;

  initial begin
    n_wr = 0; n_ld = 0; n_fs = 0;
    exp_wr = 0; exp_ld = 0; exp_fs = 0;
    prev_wr = 0; ld_chk = 1; ramp = 0; drop_en = 0;
    m_line = 0; m_word = 0;
    rst = 1'b0; vs_in = 1'b0; de_in = 1'b1; fifo_full = 1'b0; rgb = 16'h1234;

    // Reset asserted in the middle of an active line
    repeat (3) tick();
    check("rst_flags", DW'({wr_en, line_done, frame_start, ovf, frame_err}), DW'(0));
    check("rst_wr_data", wr_data, DW'(0));
    rst = 1'b1;
    repeat (5) tick();
    de_in = 1'b0;
    repeat (5) tick();
    check("no_fs_before_vs", DW'(n_fs), DW'(0));
    check("no_wr_before_vs", DW'(n_wr), DW'(0));

    // Ramp frame: known word contents
    ramp = 1;
    drive_frame(V, -1, 0);
    w0_exp = '0;
    for (int k = 0; k < 8; k++) w0_exp[k*16 +: 16] = 16'(2 * k);
    fl_exp = '0;
    fl_exp[15:0]  = 16'd32;
    fl_exp[31:16] = 16'd34;
    check("ramp_words", DW'(obs.size()), DW'(9));
    if (obs.size() > 2) begin
      check("ramp_word0", obs[0], w0_exp);
      check("ramp_flush_word", obs[2], fl_exp);
    end
    check("ramp_line_done", DW'(n_ld), DW'(3));
    check("ramp_ovf", DW'(ovf), DW'(0));

    // Random frame with three words lost to fifo_full
    ramp = 0;
    drop_en = 1;
    ld_chk = 0;
    n_wr = 0;
    drive_frame(V, -1, 0);
    drop_en = 0;
    ld_chk = 1;
    check("drop_frame_err", DW'(frame_err), DW'(0));
    check("drop_ovf", DW'(ovf), DW'(1));
    check("drop_words", DW'(n_wr), DW'(6));

    // Short frame (V-1 lines), then a frame that must still pack correctly
    drive_frame(V - 1, -1, 0);
    check("short_frame_pre_vs", DW'(frame_err), DW'(0));
    drive_frame(V, -1, 0);
    check("line_count_err", DW'(frame_err), DW'(1));
    check("ovf_sticky", DW'(ovf), DW'(1));
    check("queue_drained_1", DW'(exp_q.size()), DW'(0));

    // Bad line length on an odd line
    do_reset();
    check("reset_clears_flags", DW'({ovf, frame_err}), DW'(0));
    drive_frame(V, 1, H - 1);
    check("line_len_err", DW'(frame_err), DW'(1));
    drive_frame(V, -1, 0);
    check("queue_drained_2", DW'(exp_q.size()), DW'(0));

    // vs edge while de is high, at kept slot 5
    do_reset();
    drive_frame(0, -1, 0);
    check("pre_abort_err", DW'(frame_err), DW'(0));
    n_wr = 0;
    drive_line(H, 10);
    check("abort_no_push", DW'(n_wr), DW'(0));
    check("abort_frame_err", DW'(frame_err), DW'(1));
    check("abort_frame_start", DW'(n_fs), DW'(exp_fs));
    for (int l = 0; l < V; l++) drive_line(H, -1);
    drive_frame(0, -1, 0);
    check("post_abort_words", DW'(n_wr), DW'(9));
    check("queue_drained_3", DW'(exp_q.size()), DW'(0));
    check("total_line_done", DW'(n_ld), DW'(exp_ld));
    check("total_frame_start", DW'(n_fs), DW'(exp_fs));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
